weight_ram_arbiter: RTL and testbench

Two-port arbiter and command sequencer for the single-port synaptic-weight RAM. It shares the RAM between two requesters:
- Port A: the neuron-update scheduler's read-only weight fetch.
- Port B: the learning/loader engine's read/write port.

Arbitration is round-robin, with a bounded burst lock for port B. The block registers the RAM command, tracks in-flight reads through the RAM's registered-address latency, and returns read data to the correct port in order at one access per cycle.

---
 rtl/weight_mem_pkg.sv | 25 ++
 rtl/weight_ram_arbiter_if.sv | 48 ++++
 rtl/rr_arbiter2.sv | 64 ++++++
 rtl/weight_ram_arbiter.sv | 106 ++++++++++
 tb/tb_weight_ram_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_mem_pkg.sv
// Shared types for the synaptic-weight RAM arbiter.
// Defaults, port IDs, RAM command and read-tag records.
package weight_mem_pkg;

    localparam int DEF_WORD_WIDTH = 48;
    localparam int DEF_ADDR_WIDTH = 23;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    typedef struct packed {
        logic                      ce;
        logic                      we;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_WORD_WIDTH-1:0] wdata;
    } ram_cmd_t;

    typedef struct packed {
        logic  valid;
        port_t port;
    } rd_tag_t;

endpackage

// File: rtl/weight_ram_arbiter_if.sv
// Request/response and RAM bus of the weight RAM arbiter.
// slave: arbiter side; master: requesters plus RAM side.
interface weight_ram_arbiter_if #(
    parameter int WORD_WIDTH = weight_mem_pkg::DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = weight_mem_pkg::DEF_ADDR_WIDTH
);
    logic                  A_Req;
    logic [ADDR_WIDTH-1:0] A_Addr;
    logic                  A_Gnt;
    logic                  A_RValid;
    logic [WORD_WIDTH-1:0] A_RData;

    logic                  B_Req;
    logic                  B_Write;
    logic                  B_Lock;
    logic [ADDR_WIDTH-1:0] B_Addr;
    logic [WORD_WIDTH-1:0] B_WData;
    logic                  B_Gnt;
    logic                  B_RValid;
    logic [WORD_WIDTH-1:0] B_RData;

    logic                  RamChipEnable;
    logic                  RamWriteEnable;
    logic [ADDR_WIDTH-1:0] RamAddress;
    logic [WORD_WIDTH-1:0] RamWriteData;
    logic [WORD_WIDTH-1:0] RamReadData;

    modport slave (
        input  A_Req, A_Addr,
        input  B_Req, B_Write, B_Lock, B_Addr, B_WData,
        input  RamReadData,
        output A_Gnt, A_RValid, A_RData,
        output B_Gnt, B_RValid, B_RData,
        output RamChipEnable, RamWriteEnable,
        output RamAddress, RamWriteData
    );

    modport master (
        output A_Req, A_Addr,
        output B_Req, B_Write, B_Lock, B_Addr, B_WData,
        output RamReadData,
        input  A_Gnt, A_RValid, A_RData,
        input  B_Gnt, B_RValid, B_RData,
        input  RamChipEnable, RamWriteEnable,
        input  RamAddress, RamWriteData
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a bounded burst lock for B.
// Ports: clk, rst_n, req_a/req_b, lock_b in; one-hot gnt_a/gnt_b out.
module rr_arbiter2 #(
    parameter int MAX_BURST = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic lock_b,
    output logic gnt_a,
    output logic gnt_b
);
    import weight_mem_pkg::*;

    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] burst_cnt;
    port_t         last_gnt;
    logic          burst_full;

    assign burst_full = (burst_cnt == CW'(MAX_BURST));

    // Grants are combinational and forced low during reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rst_n) begin
            if (req_a && req_b) begin
                if (lock_b) begin
                    // Locked burst yields to A only once full.
                    gnt_a = burst_full;
                    gnt_b = !burst_full;
                end else if (last_gnt == PORT_B) begin
                    gnt_a = 1'b1;
                end else begin
                    gnt_b = 1'b1;
                end
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= PORT_B;
            burst_cnt <= '0;
        end else if (gnt_a) begin
            last_gnt  <= PORT_A;
            burst_cnt <= '0;
        end else if (gnt_b) begin
            last_gnt <= PORT_B;
            if (!lock_b)
                burst_cnt <= '0;
            else if (!burst_full)
                burst_cnt <= burst_cnt + CW'(1);
        end else begin
            burst_cnt <= '0;
        end
    end

endmodule

// File: rtl/weight_ram_arbiter.sv
// Shares the single-port weight RAM between fetch (A) and learning (B).
// Ports: Clock, Reset (async low), bus (slave modport: A/B and RAM).
module weight_ram_arbiter #(
    parameter int WORD_WIDTH = weight_mem_pkg::DEF_WORD_WIDTH,
    parameter int ADDR_WIDTH = weight_mem_pkg::DEF_ADDR_WIDTH,
    parameter int MAX_BURST  = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    weight_ram_arbiter_if.slave  bus
);
    import weight_mem_pkg::*;

    logic a_gnt;
    logic b_gnt;
    logic acc;
    logic b_wr;

    rr_arbiter2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk    (Clock),
        .rst_n  (Reset),
        .req_a  (bus.A_Req),
        .req_b  (bus.B_Req),
        .lock_b (bus.B_Lock),
        .gnt_a  (a_gnt),
        .gnt_b  (b_gnt)
    );

    assign bus.A_Gnt = a_gnt;
    assign bus.B_Gnt = b_gnt;
    assign acc       = a_gnt | b_gnt;
    assign b_wr      = b_gnt & bus.B_Write;

    logic                  ram_ce;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [WORD_WIDTH-1:0] ram_wdata;

    // Command stage; address and data hold when idle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_ce <= acc;
            ram_we <= b_wr;
            if (a_gnt) begin
                ram_addr <= bus.A_Addr;
            end else if (b_gnt) begin
                ram_addr  <= bus.B_Addr;
                ram_wdata <= bus.B_WData;
            end
        end
    end

    assign bus.RamChipEnable  = ram_ce;
    assign bus.RamWriteEnable = ram_we;
    assign bus.RamAddress     = ram_addr;
    assign bus.RamWriteData   = ram_wdata;

    // s1 rides with the command, s2 with the RAM's address latch.
    rd_tag_t s1;
    rd_tag_t s2;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            s1 <= '{valid: 1'b0, port: PORT_B};
            s2 <= '{valid: 1'b0, port: PORT_B};
        end else begin
            s1.valid <= acc & ~b_wr;
            s1.port  <= b_gnt ? PORT_B : PORT_A;
            s2       <= s1;
        end
    end

    logic                  a_rvalid;
    logic                  b_rvalid;
    logic [WORD_WIDTH-1:0] a_rdata;
    logic [WORD_WIDTH-1:0] b_rdata;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= s2.valid && (s2.port == PORT_A);
            b_rvalid <= s2.valid && (s2.port == PORT_B);
            if (s2.valid && (s2.port == PORT_A))
                a_rdata <= bus.RamReadData;
            if (s2.valid && (s2.port == PORT_B))
                b_rdata <= bus.RamReadData;
        end
    end

    assign bus.A_RValid = a_rvalid;
    assign bus.B_RValid = b_rvalid;
    assign bus.A_RData  = a_rdata;
    assign bus.B_RData  = b_rdata;

endmodule

// File: tb/tb_weight_ram_arbiter.sv
// Self-checking bench for weight_ram_arbiter.
// Directed phases plus random traffic against a transaction-level model.
module tb_weight_ram_arbiter;

    localparam int AW = 23;
    localparam int WW = 48;
    localparam int MB = 4;

    logic Clock = 1'b0;
    logic Reset = 1'b1;

    always #5 Clock = ~Clock;

    weight_ram_arbiter_if #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW)
    ) bus ();

    weight_ram_arbiter #(
        .WORD_WIDTH (WW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    function automatic logic [WW-1:0] init_val(int a);
        return {16'(a * 37 + 11), 32'(a) ^ 32'hC0DE_0000};
    endfunction

    // Single-port RAM with registered address.
    logic [WW-1:0] ram [int];
    logic [WW-1:0] ram_q = '0;

    always @(posedge Clock) begin
        if (bus.RamChipEnable) begin
            if (bus.RamWriteEnable)
                ram[int'(bus.RamAddress)] = bus.RamWriteData;
            else if (ram.exists(int'(bus.RamAddress)))
                ram_q <= ram[int'(bus.RamAddress)];
            else
                ram_q <= init_val(int'(bus.RamAddress));
        end
    end

    assign bus.RamReadData = ram_q;

    // Transaction-level reference state.
    typedef struct {
        int       due;
        bit       port_b;
        logic [WW-1:0] data;
    } resp_t;

    resp_t         q[$];
    logic [WW-1:0] shadow [int];
    bit            last_b;
    int            cnt;
    int            cyc;
    bit            got_a;
    logic          exp_ce, exp_we;
    logic [AW-1:0] exp_addr;
    logic [WW-1:0] exp_wdata, exp_ad, exp_bd;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h",
                   tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] mem_rd(int a);
        if (shadow.exists(a))
            return shadow[a];
        return init_val(a);
    endfunction

    task automatic model_reset();
        last_b    = 1'b1;
        cnt       = 0;
        q.delete();
        exp_ce    = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_ad    = '0;
        exp_bd    = '0;
    endtask

    task automatic chk_out();
        logic ea, eb;
        ea = 1'b0;
        eb = 1'b0;
        if (q.size() > 0 && q[0].due == cyc) begin
            if (q[0].port_b) begin
                eb = 1'b1;
                exp_bd = q[0].data;
            end else begin
                ea = 1'b1;
                exp_ad = q[0].data;
            end
            void'(q.pop_front());
        end
        chk("ram_ce", bus.RamChipEnable, exp_ce);
        chk("ram_we", bus.RamWriteEnable, exp_we);
        chk("ram_addr", bus.RamAddress, exp_addr);
        if (exp_we)
            chk("ram_wdata", bus.RamWriteData, exp_wdata);
        chk("a_rvalid", bus.A_RValid, ea);
        chk("b_rvalid", bus.B_RValid, eb);
        chk("a_rdata", bus.A_RData, exp_ad);
        chk("b_rdata", bus.B_RData, exp_bd);
    endtask

    // One clock: check grants mid-cycle, advance model, check outputs.
    task automatic tick();
        bit wa, wb;
        int a;
        #4;
        wa = 1'b0;
        wb = 1'b0;
        if (Reset) begin
            if (bus.A_Req && bus.B_Req) begin
                if (bus.B_Lock) begin
                    if (cnt < MB) wb = 1'b1;
                    else          wa = 1'b1;
                end else if (last_b) begin
                    wa = 1'b1;
                end else begin
                    wb = 1'b1;
                end
            end else begin
                wa = bus.A_Req;
                wb = bus.B_Req;
            end
        end
        chk("a_gnt", bus.A_Gnt, wa);
        chk("b_gnt", bus.B_Gnt, wb);
        got_a = wa;
        @(posedge Clock);
        if (!Reset) begin
            model_reset();
        end else begin
            exp_ce = wa | wb;
            exp_we = wb & bus.B_Write;
            if (wa) begin
                a = int'(bus.A_Addr);
                exp_addr = bus.A_Addr;
                q.push_back('{cyc + 3, 1'b0, mem_rd(a)});
                last_b = 1'b0;
                cnt = 0;
            end else if (wb) begin
                a = int'(bus.B_Addr);
                exp_addr = bus.B_Addr;
                exp_wdata = bus.B_WData;
                if (bus.B_Write)
                    shadow[a] = bus.B_WData;
                else
                    q.push_back('{cyc + 3, 1'b1, mem_rd(a)});
                last_b = 1'b1;
                cnt = bus.B_Lock ? ((cnt < MB) ? cnt + 1 : MB) : 0;
            end else begin
                cnt = 0;
            end
        end
        cyc++;
        #1;
        chk_out();
    endtask

    // A keeps request and address until granted.
    task automatic next_a(bit req);
        if (!(bus.A_Req && !got_a)) begin
            bus.A_Req  = req;
            bus.A_Addr = AW'($urandom_range(0, 15));
        end
    endtask

    task automatic set_b(bit req, bit wr, bit lk, int addr,
                         logic [WW-1:0] wd);
        bus.B_Req   = req;
        bus.B_Write = wr;
        bus.B_Lock  = lk;
        bus.B_Addr  = AW'(addr);
        bus.B_WData = wd;
    endtask

    task automatic rnd_b(bit lk_rand);
        set_b($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              lk_rand ? 1'($urandom_range(0, 1)) : 1'b0,
              $urandom_range(0, 15), WW'({$urandom(), $urandom()}));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            next_a(1'b0);
            set_b(1'b0, 1'b0, 1'b0, 0, '0);
            tick();
        end
    endtask

    initial begin
        bus.A_Req  = 1'b0;
        bus.A_Addr = '0;
        set_b(1'b0, 1'b0, 1'b0, 0, '0);
        got_a = 1'b0;
        cyc   = 0;
        model_reset();
        #1 Reset = 1'b0;
        @(posedge Clock);
        #1;

        // Reset held with requests toggling.
        for (int i = 0; i < 4; i++) begin
            bus.A_Req  = 1'($urandom_range(0, 1));
            bus.A_Addr = AW'($urandom_range(0, 15));
            rnd_b(1'b1);
            tick();
        end

        // Release: first A read of a known word.
        ram[5]    = 48'h00AB_1234_5678;
        shadow[5] = 48'h00AB_1234_5678;
        Reset = 1'b1;
        bus.A_Req  = 1'b1;
        bus.A_Addr = AW'(5);
        set_b(1'b0, 1'b0, 1'b0, 0, '0);
        tick();
        bus.A_Req = 1'b0;
        idle(4);

        // Contention, no lock: alternation.
        for (int i = 0; i < 8; i++) begin
            next_a(1'b1);
            set_b(1'b1, 1'b0, 1'b0, $urandom_range(0, 15), '0);
            tick();
        end
        idle(4);

        // Read after write to the same address.
        set_b(1'b1, 1'b1, 1'b0, 7, 48'h1);
        tick();
        bus.A_Req  = 1'b1;
        bus.A_Addr = AW'(7);
        set_b(1'b0, 1'b0, 1'b0, 0, '0);
        tick();
        idle(4);
        chk("raw_a_rdata", bus.A_RData, 48'h1);

        // Locked burst under contention, then A idle.
        for (int i = 0; i < 12; i++) begin
            next_a(1'b1);
            set_b(1'b1, $urandom_range(0, 1) == 0, 1'b1,
                  $urandom_range(0, 15), WW'($urandom()));
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            next_a(1'b0);
            set_b(1'b1, 1'b0, 1'b1, $urandom_range(0, 15), '0);
            tick();
        end
        idle(4);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            next_a($urandom_range(0, 3) != 0);
            rnd_b(1'b1);
            tick();
        end
        idle(5);

        // Reset with two reads in flight.
        bus.A_Req  = 1'b1;
        bus.A_Addr = AW'(3);
        tick();
        bus.A_Req = 1'b0;
        set_b(1'b1, 1'b0, 1'b0, 4, '0);
        tick();
        Reset = 1'b0;
        #1;
        chk("rst_ce", bus.RamChipEnable, 1'b0);
        chk("rst_addr", bus.RamAddress, '0);
        chk("rst_a_rvalid", bus.A_RValid, 1'b0);
        chk("rst_b_rvalid", bus.B_RValid, 1'b0);
        chk("rst_a_rdata", bus.A_RData, '0);
        chk("rst_b_rdata", bus.B_RData, '0);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            bus.A_Req = 1'($urandom_range(0, 1));
            rnd_b(1'b1);
            tick();
        end
        Reset = 1'b1;
        bus.A_Req = 1'b0;
        idle(6);

        for (int i = 0; i < 50; i++) begin
            next_a($urandom_range(0, 1) != 0);
            rnd_b(1'b1);
            tick();
        end
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
